// File: rtl/bht_update_ctrl.sv
// Branch history table update sequencer: sweeps the table to INIT_STATE after reset,
// then turns queued resolved-branch events into read-modify-writes on SRAM port 1.
module bht_update_ctrl #(
    parameter int unsigned      ADDR_W     = 5,
    parameter int unsigned      CNT_W      = 2,
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter logic [CNT_W-1:0] INIT_STATE = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_taken,
    output logic              upd_ready,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [CNT_W-1:0]  sram_din,
    input  logic [CNT_W-1:0]  sram_dout,
    output logic              init_done,
    output logic              busy
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W  = PTR_W + 1;
    localparam int unsigned SWEEP_W = ADDR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              taken;
    } upd_t;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SWEEP_W-1:0]  r_sweep;
    logic [SWEEP_W-1:0]  w_sweep_nxt;
    logic                r_csb;
    logic                w_csb_nxt;
    logic                r_web;
    logic                w_web_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [CNT_W-1:0]    r_din;
    logic [CNT_W-1:0]    w_din_nxt;
    logic                r_init_done;
    logic                w_init_done_nxt;

    upd_t                r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [FCNT_W-1:0]   r_count;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    upd_t                w_head;

    // 2-bit saturating counter step toward the resolved direction
    function automatic logic [CNT_W-1:0] f_sat(input logic [CNT_W-1:0] v, input logic up);
        if (up) begin
            return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
        end
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

    assign w_full    = (r_count == FCNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign upd_ready = r_init_done & ~w_full;
    assign w_push    = upd_valid & upd_ready;
    assign w_head    = r_fifo[r_rd_ptr];
    assign busy      = (r_state != S_IDLE) | ~w_empty;

    assign sram_csb  = r_csb;
    assign sram_web  = r_web;
    assign sram_addr = r_addr;
    assign sram_din  = r_din;
    assign init_done = r_init_done;

    // Event queue payload storage; pointers and occupancy live in the reset domain below
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {upd_addr, upd_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // State and registered SRAM command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_sweep     <= '0;
            r_csb       <= 1'b1;
            r_web       <= 1'b1;
            r_addr      <= '0;
            r_din       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep     <= w_sweep_nxt;
            r_csb       <= w_csb_nxt;
            r_web       <= w_web_nxt;
            r_addr      <= w_addr_nxt;
            r_din       <= w_din_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    // Next command: the sweep's MSB marks that every entry has been written
    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_nxt     = r_sweep;
        w_csb_nxt       = 1'b1;
        w_web_nxt       = 1'b1;
        w_addr_nxt      = r_addr;
        w_din_nxt       = r_din;
        w_init_done_nxt = r_init_done;
        w_pop           = 1'b0;

        case (r_state)
            S_INIT: begin
                if (!r_sweep[ADDR_W]) begin
                    w_csb_nxt   = 1'b0;
                    w_web_nxt   = 1'b0;
                    w_addr_nxt  = r_sweep[ADDR_W-1:0];
                    w_din_nxt   = INIT_STATE;
                    w_sweep_nxt = r_sweep + SWEEP_W'(1);
                end else begin
                    w_init_done_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!w_empty) begin
                    w_csb_nxt   = 1'b0;
                    w_addr_nxt  = w_head.addr;
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                w_pop       = 1'b1;
                w_csb_nxt   = 1'b0;
                w_web_nxt   = 1'b0;
                w_din_nxt   = f_sat(sram_dout, w_head.taken);
                w_state_nxt = S_WR;
            end
            S_WR: begin
                if (!w_empty) begin
                    w_csb_nxt   = 1'b0;
                    w_addr_nxt  = w_head.addr;
                    w_state_nxt = S_RD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Self-checking bench for bht_update_ctrl: live negedge SRAM model, write-command scoreboard,
// table-driven single updates and hand-written burst / reset sequences.
module tb_bht_update_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned NENT   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_addr = '0;
    logic              upd_taken = 1'b0;
    logic              upd_ready;
    logic              sram_csb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_addr;
    logic [CNT_W-1:0]  sram_din;
    logic [CNT_W-1:0]  sram_dout;
    logic              init_done;
    logic              busy;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  din;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              taken;
        logic [CNT_W-1:0]  init;
        logic [CNT_W-1:0]  exp;
    } vec_t;

    wr_t              exp_q[$];
    wr_t              mon_e;
    logic [CNT_W-1:0] mem     [NENT];
    logic [CNT_W-1:0] ref_tbl [NENT];
    logic [ADDR_W-1:0] b_addr [8];
    logic             b_taken [8];
    logic             prev_rd = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               stall;
    vec_t             vecs [6];

    bht_update_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (upd_valid),
        .upd_addr  (upd_addr),
        .upd_taken (upd_taken),
        .upd_ready (upd_ready),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .init_done (init_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // SRAM port 1: samples the registered command on the falling edge
    always @(negedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_addr] <= sram_din;
            else           sram_dout      <= mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat2(input logic [CNT_W-1:0] v, input logic t);
        if (t) return (v == 2'b11) ? 2'b11 : v + 2'b01;
        return (v == 2'b00) ? 2'b00 : v - 2'b01;
    endfunction

    // Scoreboard: every write command must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && !sram_csb && !sram_web) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'({sram_addr, sram_din}), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(sram_addr), 32'(mon_e.addr));
                check("wr_din", 32'(sram_din), 32'(mon_e.din));
            end
            if (init_done) check("rmw_read_before_write", 32'({prev_rd, prev_addr}), 32'({1'b1, sram_addr}));
        end
        prev_rd   <= !rst && !sram_csb && sram_web;
        prev_addr <= sram_addr;
    end

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(busy == 1'b0 && exp_q.size() == 0) && n < 300);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Sweep starting from rst=1; valid is driven during the sweep and must be ignored
    task automatic do_sweep(input string name);
        for (int i = 0; i < int'(NENT); i++) begin
            exp_q.push_back('{ADDR_W'(i), 2'b01});
            ref_tbl[i] = 2'b01;
        end
        @(negedge clk);
        rst       = 1'b0;
        upd_valid = 1'b1;
        upd_addr  = 5'd30;
        upd_taken = 1'b1;
        for (int k = 1; k <= int'(NENT); k++) begin
            @(posedge clk); #1;
            if (k == 20) upd_valid = 1'b0;
        end
        check({name, "_done_early"}, 32'(init_done), 32'd0);
        check({name, "_ready_early"}, 32'(upd_ready), 32'd0);
        @(posedge clk); #1;
        check({name, "_init_done"}, 32'(init_done), 32'd1);
        check({name, "_ready"}, 32'(upd_ready), 32'd1);
        check({name, "_csb"}, 32'(sram_csb), 32'd1);
        check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_one(input logic [ADDR_W-1:0] a, input logic t, input logic [CNT_W-1:0] e);
        int n = 0;
        @(negedge clk);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_taken = t;
        while (!upd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(upd_ready), 32'd1);
        exp_q.push_back('{a, e});
        ref_tbl[a] = e;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    // valid held high; an event counts as accepted when ready is high before the edge
    task automatic burst(input int n, output int saw_stall);
        int  idx = 0;
        int  cyc = 0;
        bit  acc;
        logic [CNT_W-1:0] e;
        saw_stall = 0;
        @(negedge clk);
        upd_valid = 1'b1;
        upd_addr  = b_addr[0];
        upd_taken = b_taken[0];
        while (idx < n && cyc < 300) begin
            acc = upd_ready;
            if (!acc) saw_stall = 1;
            if (acc) begin
                e = sat2(ref_tbl[upd_addr], upd_taken);
                ref_tbl[upd_addr] = e;
                exp_q.push_back('{upd_addr, e});
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < n) begin
                    upd_addr  = b_addr[idx];
                    upd_taken = b_taken[idx];
                end else begin
                    upd_valid = 1'b0;
                end
            end
            cyc++;
            if (idx < n) @(negedge clk);
        end
        upd_valid = 1'b0;
        check("burst_accepted", 32'(idx), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5'd7,  1'b1, 2'b01, 2'b10};
        vecs[1] = '{5'd5,  1'b1, 2'b11, 2'b11};
        vecs[2] = '{5'd9,  1'b0, 2'b00, 2'b00};
        vecs[3] = '{5'd10, 1'b0, 2'b10, 2'b01};
        vecs[4] = '{5'd11, 1'b1, 2'b10, 2'b11};
        vecs[5] = '{5'd13, 1'b0, 2'b11, 2'b10};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_csb", 32'(sram_csb), 32'd1);
        check("rst_web", 32'(sram_web), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_din", 32'(sram_din), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_ready", 32'(upd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        do_sweep("sweep");
        wait_idle("post_sweep");

        // Single updates, including saturation corners, with exact read/write timing
        for (int v = 0; v < 6; v++) begin
            mem[vecs[v].addr]     = vecs[v].init;
            ref_tbl[vecs[v].addr] = vecs[v].init;
            push_one(vecs[v].addr, vecs[v].taken, vecs[v].exp);
            @(posedge clk); #1;
            check("vec_rd_cmd", 32'({sram_csb, sram_web, sram_addr}), 32'({1'b0, 1'b1, vecs[v].addr}));
            @(posedge clk); #1;
            check("vec_wr_cmd", 32'({sram_csb, sram_web, sram_addr, sram_din}),
                  32'({1'b0, 1'b0, vecs[v].addr, vecs[v].exp}));
            wait_idle("vec_idle");
            check("vec_csb_idle", 32'(sram_csb), 32'd1);
        end

        // Three back-to-back taken updates to one entry starting at 01
        mem[3]     = 2'b01;
        ref_tbl[3] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            b_addr[i]  = 5'd3;
            b_taken[i] = 1'b1;
        end
        burst(3, stall);
        wait_idle("b2b_idle");
        check("b2b_final_entry", 32'(mem[3]), 32'(2'b11));

        // Eight events with valid held: queue fills and ready must drop
        b_addr  = '{5'd3, 5'd3, 5'd20, 5'd3, 5'd21, 5'd20, 5'd3, 5'd22};
        b_taken = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        burst(8, stall);
        check("burst_ready_dropped", 32'(stall), 32'd1);
        wait_idle("burst_idle");
        check("burst_entry3", 32'(mem[3]), 32'(ref_tbl[3]));
        check("burst_entry20", 32'(mem[20]), 32'(ref_tbl[20]));

        // Reset while the write of entry 12 is in flight with three events still queued
        b_addr  = '{5'd1, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd0, 5'd0};
        b_taken = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        burst(5, stall);
        check("rstmid_in_wr12", 32'({sram_csb, sram_web, sram_addr}), 32'({1'b0, 1'b0, 5'd12}));
        check("rstmid_pending", 32'(exp_q.size()), 32'd4);
        rst = 1'b1;
        #1;
        check("rstmid_csb", 32'(sram_csb), 32'd1);
        check("rstmid_ready", 32'(upd_ready), 32'd0);
        check("rstmid_init_done", 32'(init_done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        do_sweep("resweep");
        repeat (10) @(posedge clk);
        #1;
        check("resweep_busy", 32'(busy), 32'd0);
        check("resweep_csb", 32'(sram_csb), 32'd1);
        check("resweep_entry12", 32'(mem[12]), 32'(2'b01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
